// File: rtl/pingpong_write_ctrl.sv
// Upstream half of the BRAM ping-pong buffer: packs a valid/ready stream into
// DEPTH-word frames alternating between two banks and hands frames to the reader.
module pingpong_write_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              bram0_we,
  output logic              bram1_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              rd_start,
  output logic              rd_bank,
  input  logic              rd_done,
  output logic [1:0]        full
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} rd_state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  rd_state_t         rd_state;
  logic              busy;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_cnt;
  logic              accept;
  logic              frame_last;
  logic [1:0]        full_set;
  logic [1:0]        full_clr;

  assign busy       = (rd_state == BUSY);
  assign s_ready    = ~full[wr_bank];
  assign accept     = s_valid & s_ready;
  assign frame_last = accept && (wr_cnt == LAST);

  // Set and clear can hit the same edge; they never target the same bank
  // because the writer only fills a bank whose flag is clear.
  assign full_set = frame_last ? (2'b01 << wr_bank) : 2'b00;
  assign full_clr = (busy && rd_done) ? (2'b01 << rd_bank) : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      bram0_we  <= 1'b0;
      bram1_we  <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
    end else begin
      bram0_we <= accept && !wr_bank;
      bram1_we <= accept &&  wr_bank;
      if (accept) begin
        bram_addr <= wr_cnt;
        bram_din  <= s_data;
        if (frame_last) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt  <= wr_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) full <= 2'b00;
    else     full <= (full & ~full_clr) | full_set;
  end

  // Reader handshake: rd_bank only advances on release, so frames are
  // consumed strictly in fill order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state <= IDLE;
      rd_start <= 1'b0;
      rd_bank  <= 1'b0;
    end else begin
      rd_start <= 1'b0;
      case (rd_state)
        IDLE: if (full[rd_bank]) begin
          rd_state <= BUSY;
          rd_start <= 1'b1;
        end
        BUSY: if (rd_done) begin
          rd_state <= IDLE;
          rd_bank  <= ~rd_bank;
        end
        default: rd_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pingpong_write_ctrl.sv
// Bench for pingpong_write_ctrl: directed vector table, corner-case sequences,
// and a randomized run against a frame-counting reference model.
module tb_pingpong_write_ctrl;
  localparam int DW = 8;
  localparam int AW = 6;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          bram0_we, bram1_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic          rd_start, rd_bank;
  logic          rd_done = 1'b0;
  logic [1:0]    full;

  int checks = 0;
  int errors = 0;

  pingpong_write_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .bram0_we(bram0_we), .bram1_we(bram1_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .rd_start(rd_start), .rd_bank(rd_bank),
    .rd_done(rd_done), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          done;
    logic          ready;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          start;
    logic          bank;
    logic [1:0]    fl;
  } vec_t;

  vec_t tbl[12];

  // reference model: frames counted, not registers
  int            m_k, m_comp, m_rel, outst, cd;
  bit            m_busy, ract, acc;
  logic          e_we0, e_we1, e_start;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din;
  logic [1:0]    e_full;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; rd_done = 1'b0; s_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".we0"}, bram0_we, 0);
    chk({tag, ".we1"}, bram1_we, 0);
    chk({tag, ".addr"}, bram_addr, 0);
    chk({tag, ".din"}, bram_din, 0);
    chk({tag, ".start"}, rd_start, 0);
    chk({tag, ".bank"}, rd_bank, 0);
    chk({tag, ".full"}, full, 0);
    chk({tag, ".ready"}, s_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    // reset state
    @(negedge clk);
    chk_zero("reset");

    // ---- vector table: single frame, reader idle, spurious rd_done ----
    tbl[0] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 1'b0, 2'b00};
    for (int j = 0; j < 8; j++)
      tbl[1+j] = '{1'b1, 8'(8'h10 + j), 1'b0, 1'b1, 1'b1, 1'b0, 6'(j), 8'(8'h10 + j),
                   1'b0, 1'b0, (j == 7) ? 2'b01 : 2'b00};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 6'd7, 8'h17, 1'b1, 1'b0, 2'b01};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 6'd7, 8'h17, 1'b0, 1'b1, 2'b00};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 6'd7, 8'h17, 1'b0, 1'b1, 2'b00};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      s_valid = tbl[i].v; s_data = tbl[i].d; rd_done = tbl[i].done;
      chk($sformatf("vec%0d.ready", i), s_ready, tbl[i].ready);
      tick();
      chk($sformatf("vec%0d.we0", i), bram0_we, tbl[i].we0);
      chk($sformatf("vec%0d.we1", i), bram1_we, tbl[i].we1);
      chk($sformatf("vec%0d.addr", i), bram_addr, tbl[i].addr);
      chk($sformatf("vec%0d.din", i), bram_din, tbl[i].din);
      chk($sformatf("vec%0d.start", i), rd_start, tbl[i].start);
      chk($sformatf("vec%0d.bank", i), rd_bank, tbl[i].bank);
      chk($sformatf("vec%0d.full", i), full, tbl[i].fl);
    end
    rd_done = 1'b0;

    // ---- ping-pong with reader held busy, then stall and release ----
    do_reset();
    for (int w = 0; w < 16; w++) begin
      s_valid = 1'b1; s_data = 8'(w); rd_done = 1'b0;
      tick();
      chk($sformatf("pp.w%0d.we0", w), bram0_we, w < 8);
      chk($sformatf("pp.w%0d.we1", w), bram1_we, w >= 8);
      chk($sformatf("pp.w%0d.addr", w), bram_addr, w % 8);
    end
    chk("pp.full11", full, 2'b11);
    chk("pp.ready0", s_ready, 0);
    chk("pp.bank0", rd_bank, 0);
    s_valid = 1'b1; s_data = 8'hAA;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("pp.stall%0d.we0", k), bram0_we, 0);
      chk($sformatf("pp.stall%0d.we1", k), bram1_we, 0);
    end
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    chk("pp.rel.we0", bram0_we, 0);
    chk("pp.rel.full", full, 2'b10);
    chk("pp.rel.bank", rd_bank, 1);
    chk("pp.rel.ready", s_ready, 1);
    tick();
    s_valid = 1'b0;
    chk("pp.w16.we0", bram0_we, 1);
    chk("pp.w16.addr", bram_addr, 0);
    chk("pp.w16.din", bram_din, 8'hAA);
    chk("pp.w16.start", rd_start, 1);
    chk("pp.w16.bank", rd_bank, 1);

    // ---- gappy producer ----
    do_reset();
    for (int i = 0; i < 16; i++) begin
      s_valid = (i % 2 == 0); s_data = 8'(8'h40 + i / 2);
      tick();
      chk($sformatf("gap%0d.we0", i), bram0_we, i % 2 == 0);
      chk($sformatf("gap%0d.addr", i), bram_addr, i / 2);
      chk($sformatf("gap%0d.din", i), bram_din, 8'h40 + i / 2);
    end
    s_valid = 1'b0;
    chk("gap.full", full, 2'b01);

    // ---- simultaneous bank1 completion and bank0 release ----
    do_reset();
    for (int w = 0; w < 16; w++) begin
      s_valid = 1'b1; s_data = 8'(w); rd_done = (w == 15);
      tick();
    end
    s_valid = 1'b0; rd_done = 1'b0;
    chk("sim.full10", full, 2'b10);
    chk("sim.start0", rd_start, 0);
    chk("sim.bank1", rd_bank, 1);
    tick();
    chk("sim.start1", rd_start, 1);
    chk("sim.bank1b", rd_bank, 1);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    chk("sim.full00", full, 2'b00);
    chk("sim.bank0", rd_bank, 0);

    // ---- async reset mid-frame ----
    do_reset();
    for (int w = 0; w < 5; w++) begin
      s_valid = 1'b1; s_data = 8'(8'h50 + w);
      tick();
    end
    s_valid = 1'b0;
    chk("ar.pre.addr", bram_addr, 4);
    chk("ar.pre.din", bram_din, 8'h54);
    #2 rst = 1'b1;
    #1 chk_zero("ar.async");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int w = 0; w < 7; w++) begin
      s_valid = 1'b1; s_data = 8'(8'h60 + w);
      tick();
      if (w == 0) begin
        chk("ar.w0.we0", bram0_we, 1);
        chk("ar.w0.addr", bram_addr, 0);
        chk("ar.w0.din", bram_din, 8'h60);
      end
    end
    s_valid = 1'b0;
    tick();
    chk("ar.nofull", full, 0);
    chk("ar.nostart", rd_start, 0);
    s_valid = 1'b1; s_data = 8'h67;
    tick();
    s_valid = 1'b0;
    chk("ar.full", full, 2'b01);
    tick();
    chk("ar.start", rd_start, 1);
    chk("ar.bank", rd_bank, 0);

    // ---- randomized run against frame-counting model ----
    do_reset();
    m_k = 0; m_comp = 0; m_rel = 0; m_busy = 0; ract = 0; cd = 0;
    for (int c = 0; c < 3000; c++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 8'($urandom);
      rd_done = 1'b0;
      if (ract) begin
        if (cd == 0) begin rd_done = 1'b1; ract = 0; end
        else cd--;
      end else if ($urandom_range(0, 15) == 0) rd_done = 1'b1;
      outst = m_comp - m_rel;
      chk("rnd.ready", s_ready, outst < 2);
      acc   = s_valid && (outst < 2);
      e_we0 = acc && ((m_k / D) % 2 == 0);
      e_we1 = acc && ((m_k / D) % 2 == 1);
      if (acc) begin e_addr = 6'(m_k % D); e_din = s_data; m_k++; end
      e_start = 1'b0;
      if (!m_busy && outst > 0) begin e_start = 1'b1; m_busy = 1; end
      else if (m_busy && rd_done) begin m_rel++; m_busy = 0; end
      if (acc && (m_k % D == 0)) m_comp++;
      tick();
      outst  = m_comp - m_rel;
      e_full = (outst == 0) ? 2'b00 : (outst == 1) ? ((m_rel % 2 == 1) ? 2'b10 : 2'b01) : 2'b11;
      chk("rnd.we0", bram0_we, e_we0);
      chk("rnd.we1", bram1_we, e_we1);
      if (e_we0 || e_we1) begin
        chk("rnd.addr", bram_addr, e_addr);
        chk("rnd.din", bram_din, e_din);
      end
      chk("rnd.start", rd_start, e_start);
      chk("rnd.bank", rd_bank, m_rel % 2);
      chk("rnd.full", full, e_full);
      if (rd_start) begin
        ract = 1;
        cd = $urandom_range(0, (c < 1500) ? 5 : 25);
      end
    end
    s_valid = 1'b0; rd_done = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
